// File: rtl/oh_irq_pkg.sv
// Shared types for the interrupt collector: FSM state encoding.
package oh_irq_pkg;

    localparam int unsigned StateW = 2;

    typedef enum logic [StateW-1:0] {
        StIdle   = 2'd0,
        StAssert = 2'd1,
        StHold   = 2'd2
    } irq_state_e;

endpackage

// File: rtl/oh_dsync.sv
// Two-flop synchronizer, DW bits wide, flops reset to 0.
module oh_dsync #(
    parameter int unsigned DW = 1
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    input  logic [DW-1:0] d_i,
    output logic [DW-1:0] q_o
);

    logic [DW-1:0] meta_q;
    logic [DW-1:0] sync_q;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/oh_irq_collect.sv
// Interrupt collector: edge capture into sticky status, holdoff-limited irq, event counter.
// Define OH_IRQ_SYNC_EN to pass event_in through a 2-flop synchronizer first.
module oh_irq_collect
    import oh_irq_pkg::*;
#(
    parameter int unsigned DW      = 1,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned CW      = 8
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    input  logic [DW-1:0] event_in_i,
    input  logic [DW-1:0] en_i,
    input  logic          clr_valid_i,
    input  logic [DW-1:0] clr_mask_i,
    input  logic          cnt_clr_i,
    output logic [DW-1:0] status_o,
    output logic          irq_o,
    output logic [CW-1:0] evt_count_o
);

    localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HoldLoad = (HOLDOFF > 0) ? HW'(HOLDOFF - 1) : '0;
    localparam logic [CW-1:0] CntMax = '1;

    logic [DW-1:0] event_s;
    logic [DW-1:0] event_q;
    logic [DW-1:0] rise;
    logic [DW-1:0] status_q, status_d;
    logic          pending;
    irq_state_e    state_q, state_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          irq_q, irq_d;
    logic [CW-1:0] evt_count_q, evt_count_d;

`ifdef OH_IRQ_SYNC_EN
    oh_dsync #(
        .DW(DW)
    ) u_dsync (
        .clk_i   (clk_i),
        .nreset_i(nreset_i),
        .d_i     (event_in_i),
        .q_o     (event_s)
    );
`else
    assign event_s = event_in_i;
`endif

    assign rise    = event_s & ~event_q;
    assign pending = |(status_q & en_i);

    // New rises are OR-ed in after the clear so a coincident set wins.
    always_comb begin
        status_d = status_q;
        if (clr_valid_i) begin
            status_d = status_q & ~clr_mask_i;
        end
        status_d = status_d | rise;
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (pending) begin
                    state_d = StAssert;
                end
            end
            StAssert: begin
                if (!pending) begin
                    if (HOLDOFF > 0) begin
                        state_d    = StHold;
                        hold_cnt_d = HoldLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                // Leave on the edge the counter reaches 0; the IDLE cycle closes the window.
                if (hold_cnt_q <= HW'(1)) begin
                    state_d    = StIdle;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                hold_cnt_d = '0;
            end
        endcase
    end

    assign irq_d = (state_d == StAssert);

    always_comb begin
        evt_count_d = evt_count_q;
        if (cnt_clr_i) begin
            evt_count_d = '0;
        end else if ((|(rise & en_i)) && (evt_count_q != CntMax)) begin
            evt_count_d = evt_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            event_q     <= '0;
            status_q    <= '0;
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            irq_q       <= 1'b0;
            evt_count_q <= '0;
        end else begin
            event_q     <= event_s;
            status_q    <= status_d;
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            irq_q       <= irq_d;
            evt_count_q <= evt_count_d;
        end
    end

    assign status_o    = status_q;
    assign irq_o       = irq_q;
    assign evt_count_o = evt_count_q;

endmodule

// File: tb/tb_oh_irq_collect.sv
// Scoreboard bench for oh_irq_collect (DW=4, HOLDOFF=4, CW=2).
module tb_oh_irq_collect;

`ifdef OH_IRQ_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    typedef struct {
        string      name;
        logic [3:0] ev;
        logic [3:0] en;
        logic       clr;
        logic [3:0] mask;
        logic       cclr;
        logic [6:0] exp;  // {status, irq, evt_count}
    } stim_t;

    logic       clk;
    logic       nreset;
    logic [3:0] event_in;
    logic [3:0] en;
    logic       clr_valid;
    logic [3:0] clr_mask;
    logic       cnt_clr;
    logic [3:0] status;
    logic       irq;
    logic [1:0] evt_count;

    stim_t sb[$];
    int    checks = 0;
    int    passed = 0;

    oh_irq_collect #(
        .DW     (4),
        .HOLDOFF(4),
        .CW     (2)
    ) dut (
        .clk_i      (clk),
        .nreset_i   (nreset),
        .event_in_i (event_in),
        .en_i       (en),
        .clr_valid_i(clr_valid),
        .clr_mask_i (clr_mask),
        .cnt_clr_i  (cnt_clr),
        .status_o   (status),
        .irq_o      (irq),
        .evt_count_o(evt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input stim_t s);
        event_in  = s.ev;
        en        = s.en;
        clr_valid = s.clr;
        clr_mask  = s.mask;
        cnt_clr   = s.cclr;
    endtask

    function automatic logic [6:0] observed();
        return {status, irq, evt_count};
    endfunction

    task automatic test_reset();
        stim_t      e;
        logic [6:0] o;
        nreset = 1'b0;
        drive('{"init", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'b0});
        sb.push_back('{"reset_state", 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'b0000_0_00});
        #3;
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e.exp)
            $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                     e.exp[6:3], e.exp[2], e.exp[1:0]);
        else passed++;
        @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic test_enabled_rise();
        stim_t      s[$];
        stim_t      e;
        logic [6:0] o;
        s.push_back('{"idle",         4'b0000, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0000_0_00});
        s.push_back('{"rise0_status", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_0_01});
        s.push_back('{"rise0_irq",    4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_1_01});
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(s[i]);
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                         e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    task automatic test_disabled_rise();
        stim_t      s[$];
        stim_t      e;
        logic [6:0] o;
        s.push_back('{"rise2_status", 4'b0101, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0101_1_01});
        s.push_back('{"rise2_held",   4'b0101, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0101_1_01});
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(s[i]);
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                         e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    task automatic test_set_wins();
        stim_t      s[$];
        stim_t      e;
        logic [6:0] o;
        s.push_back('{"bit0_low",  4'b0100, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0101_1_01});
        s.push_back('{"set_wins",  4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 7'b0101_1_10});
        s.push_back('{"after_clr", 4'b0101, 4'b0011, 1'b0, 4'b1111, 1'b0, 7'b0101_1_10});
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(s[i]);
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                         e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    task automatic test_holdoff();
        stim_t      s[$];
        stim_t      e;
        logic [6:0] o;
        s.push_back('{"clr_all",    4'b0000, 4'b0011, 1'b1, 4'b1111, 1'b0, 7'b0000_1_10});
        s.push_back('{"hold_low1",  4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_0_11});
        s.push_back('{"hold_low2",  4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_0_11});
        s.push_back('{"hold_low3",  4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_0_11});
        s.push_back('{"hold_low4",  4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_0_11});
        s.push_back('{"hold_reirq", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0001_1_11});
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(s[i]);
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                         e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    task automatic test_saturate();
        stim_t      s[$];
        stim_t      e;
        logic [6:0] o;
        s.push_back('{"cnt_clr",  4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b1, 7'b0001_1_00});
        s.push_back('{"sat1",     4'b0010, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_1_01});
        s.push_back('{"sat2",     4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_1_10});
        s.push_back('{"sat3",     4'b0010, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_1_11});
        s.push_back('{"sat4",     4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_1_11});
        s.push_back('{"sat5",     4'b0010, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_1_11});
        s.push_back('{"clr_wins", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b1, 7'b0011_1_00});
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(s[i]);
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                         e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    task automatic test_en_clear();
        stim_t      s[$];
        stim_t      e;
        logic [6:0] o;
        s.push_back('{"en_off",   4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 7'b0011_0_00});
        s.push_back('{"en_hold1", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_0_00});
        s.push_back('{"en_hold2", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_0_00});
        s.push_back('{"en_hold3", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_0_00});
        s.push_back('{"en_reirq", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011_1_00});
        foreach (s[i]) begin
            drive(s[i]);
            sb.push_back(s[i]);
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                         e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    // Async reset while irq is high, then capture latency of a level already high.
    task automatic test_async_reset();
        stim_t      e;
        logic [6:0] o;
        logic [6:0] x;
        drive('{"pre", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0});
        @(posedge clk);
        #3;
        nreset = 1'b0;
        sb.push_back('{"async_rst", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0000_0_00});
        #1;
        e = sb.pop_front();
        o = observed();
        checks++;
        if (o !== e.exp)
            $display("FAIL %s: got %b/%b/%0d want %b/%b/%0d", e.name, o[6:3], o[2], o[1:0],
                     e.exp[6:3], e.exp[2], e.exp[1:0]);
        else passed++;
        @(negedge clk);
        nreset = 1'b1;
        for (int i = 0; i <= Lat + 1; i++) begin
            x = (i < Lat) ? 7'b0000_0_00 : (i == Lat) ? 7'b0001_0_01 : 7'b0001_1_01;
            sb.push_back('{"post_rst_capture", 4'b0001, 4'b0011, 1'b0, 4'b0000, 1'b0, x});
            tick();
            e = sb.pop_front();
            o = observed();
            checks++;
            if (o !== e.exp)
                $display("FAIL %s[%0d]: got %b/%b/%0d want %b/%b/%0d", e.name, i, o[6:3], o[2],
                         o[1:0], e.exp[6:3], e.exp[2], e.exp[1:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
`ifndef OH_IRQ_SYNC_EN
        test_enabled_rise();
        test_disabled_rise();
        test_set_wins();
        test_holdoff();
        test_saturate();
        test_en_clear();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
